// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: multi-cycle sign|exp|mant floating-point add/subtract with round-to-nearest-even and valid/ready handshakes
module fpu_addsub_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                       clock100KHz,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       op_A_in,
  input  logic [EXP_W+MAN_W:0]       op_B_in,
  input  logic                       op_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       data_out,
  output logic [3:0]                 status_out
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int XW = MAN_W + 4;
  localparam logic [EXP_W:0] ONE = 1;
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  typedef enum logic [2:0] {IDLE, ALIGN, OPER, NORM, ROUND, DONE} state_t;
  state_t state;
  logic [W-1:0] a_q, b_q;
  logic [XW-1:0] xa, xb;
  logic [XW:0] sum;
  logic [EXP_W:0] exp_r;
  logic sr, ovf, unf, zero;
  logic [EXP_W-1:0] ea, eb, d;
  logic a_big, sa, sb, inc, inexact, ovf_fin;
  logic [XW-1:0] xa_raw, xb_raw, sm, shifted;
  logic [XW:0] mag;
  logic [MAN_W+1:0] rnd;
  logic [EXP_W:0] exp_up, exp_fin;
  logic [MAN_W-1:0] man_fin;
  assign in_ready = state == IDLE;
  always_comb begin
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    sa = a_q[W-1];
    sb = b_q[W-1];
    xa_raw = ea != '0 ? {1'b1, a_q[MAN_W-1:0], 3'b000} : '0;
    xb_raw = eb != '0 ? {1'b1, b_q[MAN_W-1:0], 3'b000} : '0;
    a_big = ea >= eb;
    d = a_big ? ea - eb : eb - ea;
    sm = a_big ? xb_raw : xa_raw;
    shifted = int'(d) >= XW - 1 ? XW'(|sm)
            : (sm >> d) | XW'(|(sm & ((XW'(1) << d) - XW'(1))));
    mag = sa == sb ? {1'b0, xa} + {1'b0, xb}
        : xa >= xb ? {1'b0, xa - xb} : {1'b0, xb - xa};
    exp_up = exp_r + ONE;
    inc = sum[2] & (sum[1] | sum[0] | sum[3]);
    inexact = |sum[2:0];
    rnd = {1'b0, sum[XW-1:3]} + (MAN_W+2)'(inc);
    exp_fin = rnd[MAN_W+1] ? exp_up : exp_r;
    man_fin = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    ovf_fin = ovf | (exp_fin >= EMAX);
  end
  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      xa <= '0;
      xb <= '0;
      sum <= '0;
      exp_r <= '0;
      sr <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      zero <= 1'b0;
      out_valid <= 1'b0;
      data_out <= '0;
      status_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= op_A_in;
          b_q <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
          ovf <= (&op_A_in[W-2:MAN_W]) | (&op_B_in[W-2:MAN_W]);
          unf <= 1'b0;
          zero <= 1'b0;
          state <= ALIGN;
        end
        ALIGN: begin
          xa <= a_big ? xa_raw : shifted;
          xb <= a_big ? shifted : xb_raw;
          exp_r <= {1'b0, a_big ? ea : eb};
          state <= OPER;
        end
        OPER: begin
          sum <= mag;
          sr <= sa != sb && xb > xa ? sb : sa;
          state <= NORM;
        end
        NORM: if (ovf) state <= ROUND;
        else if (sum == '0) begin
          zero <= 1'b1;
          state <= ROUND;
        end else if (sum[XW]) begin
          sum <= {1'b0, sum[XW:2], sum[1] | sum[0]};
          exp_r <= exp_up;
          if (exp_up >= EMAX) begin
            ovf <= 1'b1;
            state <= ROUND;
          end
        end else if (!sum[XW-1]) begin
          if (exp_r == ONE) begin
            unf <= 1'b1;
            state <= ROUND;
          end else begin
            sum <= sum << 1;
            exp_r <= exp_r - ONE;
          end
        end else state <= ROUND;
        ROUND: begin
          out_valid <= 1'b1;
          data_out <= zero || ovf_fin || unf ? '0 : {sr, exp_fin[EXP_W-1:0], man_fin};
          status_out <= zero ? 4'b0001 : ovf_fin ? 4'b0100 : unf ? 4'b1000 : inexact ? 4'b0010 : 4'b0001;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
